// File: rtl/oet_sort_ctrl.sv
// oet_sort_ctrl: odd-even transposition sort controller.
// Loads a frame of DEPTH unsigned keys, sorts them ascending using a single
// nibble-sliced comparator (one compare-exchange per cycle), then streams the
// sorted frame out on a valid/ready interface.
// Optional feature macro: SORT_EARLY_EXIT_EN. When it is defined, SORT ends
// after an odd pass if neither that pass nor the even pass before it swapped
// anything. The sorted result is the same either way; only latency changes.
//
// state | meaning
// LOAD  | accepting keys into mem[wr_idx]
// SORT  | one compare-exchange of mem[k], mem[k+1] per cycle
// DRAIN | presenting mem[rd_idx] downstream
module oet_sort_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_busy
);

  localparam int NIB   = DATA_W / 4;
  localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] EVEN_LAST = IDX_W'(DEPTH - 2);
  localparam logic [IDX_W-1:0] ODD_LAST  = IDX_W'(DEPTH - 3);
  localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);
  localparam logic [IDX_W-1:0] TWO       = IDX_W'(2);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wr_idx, rd_idx, pass_cnt, pair_idx, pair_hi;
  logic [DATA_W-1:0] key_a, key_b;
  logic              accept, emit, load_done, drain_done;
  logic              swap, pass_end, last_pass, early_done, sort_exit;

  // Unsigned a < b built from 4-bit less/equal slices, combined MSB-first.
  function automatic logic key_less(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
    logic lt;
    logic eq;
    lt = 1'b0;
    eq = 1'b1;
    for (int n = NIB - 1; n >= 0; n--) begin
      lt = lt | (eq & (a[4*n +: 4] < b[4*n +: 4]));
      eq = eq & (a[4*n +: 4] == b[4*n +: 4]);
    end
    return lt;
  endfunction

  // Handshakes use the state register directly so no input reaches the
  // ready/valid outputs combinationally.
  assign accept     = i_valid && (state == LOAD);
  assign emit       = i_ready && (state == DRAIN);
  assign load_done  = accept && (wr_idx == LAST_IDX);
  assign drain_done = emit && (rd_idx == LAST_IDX);

  assign pair_hi = pair_idx + ONE;
  assign key_a   = mem[pair_idx];
  assign key_b   = mem[pair_hi];
  assign swap    = (state == SORT) && key_less(key_b, key_a);

  // Even passes end at pair DEPTH-2, odd passes at DEPTH-3. With DEPTH=2 the
  // odd pass is empty, so the single even pass is already the last one.
  assign pass_end  = pass_cnt[0] ? (pair_idx == ODD_LAST) : (pair_idx == EVEN_LAST);
  assign last_pass = (pass_cnt == LAST_IDX) || (DEPTH == 2);
  assign sort_exit = (state == SORT) && pass_end &&
                     (last_pass || (pass_cnt[0] && early_done));

`ifdef SORT_EARLY_EXIT_EN
  logic swap_flag;

  // Swap flag spans an even pass and the odd pass after it; cleared when
  // that odd pass completes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      swap_flag <= 1'b0;
    end else if (load_done) begin
      swap_flag <= 1'b0;
    end else if (state == SORT) begin
      if (pass_end && pass_cnt[0]) swap_flag <= 1'b0;
      else                         swap_flag <= swap_flag | swap;
    end
  end

  assign early_done = !(swap_flag || swap);
`else
  assign early_done = 1'b0;
`endif

  assign o_data = mem[rd_idx];
  assign o_last = o_valid && (rd_idx == LAST_IDX);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= LOAD;
    else          state <= state_nxt;
  end

  // Next-state logic and state-decoded stream outputs.
  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_busy    = 1'b0;
    case (state)
      LOAD: begin
        o_ready = 1'b1;
        if (load_done) state_nxt = SORT;
      end
      SORT: begin
        o_busy = 1'b1;
        if (sort_exit) state_nxt = DRAIN;
      end
      DRAIN: begin
        o_valid = 1'b1;
        if (drain_done) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Key buffer, load/drain pointers and the pass/pair schedule.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      pass_cnt <= '0;
      pair_idx <= '0;
    end else begin
      if (accept) begin
        mem[wr_idx] <= i_data;
        wr_idx      <= load_done ? '0 : wr_idx + ONE;
      end
      if (load_done) begin
        pass_cnt <= '0;
        pair_idx <= '0;
      end
      if (state == SORT) begin
        if (swap) begin
          mem[pair_idx] <= key_b;
          mem[pair_hi]  <= key_a;
        end
        if (sort_exit) begin
          pass_cnt <= '0;
          pair_idx <= '0;
        end else if (pass_end) begin
          pass_cnt <= pass_cnt + ONE;
          pair_idx <= pass_cnt[0] ? '0 : ONE;
        end else begin
          pair_idx <= pair_idx + TWO;
        end
      end
      if (emit) rd_idx <= drain_done ? '0 : rd_idx + ONE;
    end
  end

endmodule
